// File: rtl/bitcount_seq_unit.sv
// bitcount_seq_unit: multi-cycle CLZ/CLO execution unit.
// A single BYTE_W-wide leading-bit scanner walks the operand one byte per
// cycle, MSB byte first, accumulating the leading count. Request and response
// both use valid/ready handshakes.
// Build option: BITCNT_EARLY_EXIT_EN, when defined, stops the scan at the first
// byte that is not fully saturated. Results match in both builds; only the
// latency differs.
module bitcount_seq_unit #(
    parameter int DATA_W = 32,
    parameter int BYTE_W = 8,
    parameter int TAG_W  = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_i,
    input  logic              req_valid_i,
    output logic              req_ready_o,
    input  logic              cnt_en_i,
    input  logic [DATA_W-1:0] val_i,
    input  logic [TAG_W-1:0]  tag_i,
    output logic              resp_valid_o,
    input  logic              resp_ready_i,
    output logic [DATA_W-1:0] res_o,
    output logic [TAG_W-1:0]  tag_o,
    output logic              busy_o
);

    localparam int NBYTES = DATA_W / BYTE_W;
    localparam int IDX_W  = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam int CNT_W  = $clog2(BYTE_W + 1);
    localparam int ACC_W  = $clog2(DATA_W + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SCAN = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Number of leading bits of b_v (from its MSB) equal to pol.
    function automatic logic [CNT_W-1:0] lead_cnt(input logic [BYTE_W-1:0] b_v,
                                                  input logic pol);
        logic [CNT_W-1:0] n;
        logic             run;
        n   = CNT_W'(0);
        run = 1'b1;
        for (int i = BYTE_W - 1; i >= 0; i--) begin
            if (run && (b_v[i] == pol)) begin
                n = n + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
        return n;
    endfunction

    logic [1:0]        state_r;
    logic [1:0]        state_nxt_s;
    logic [DATA_W-1:0] val_r;
    logic              op_r;
    logic [TAG_W-1:0]  tag_r;
    logic [IDX_W-1:0]  idx_r;
    logic [ACC_W-1:0]  acc_r;
    logic [DATA_W-1:0] res_r;
    logic [TAG_W-1:0]  tag_out_r;
    logic              resp_valid_r;
    logic              busy_r;
`ifndef BITCNT_EARLY_EXIT_EN
    logic              stop_r;
`endif

    logic              accept_s;
    logic [BYTE_W-1:0] byte_s;
    logic [CNT_W-1:0]  cnt_s;
    logic              sat_s;
    logic [CNT_W-1:0]  add_s;
    logic              last_s;
    logic [ACC_W-1:0]  acc_nxt_s;

    assign accept_s     = (state_r == ST_IDLE) && req_valid_i && !flush_i;
    assign req_ready_o  = (state_r == ST_IDLE) && !flush_i && !rst;
    assign resp_valid_o = resp_valid_r;
    assign res_o        = res_r;
    assign tag_o        = tag_out_r;
    assign busy_o       = busy_r;

    // Scan datapath: count the current byte and decide whether this is the last scan cycle.
    always_comb begin
        byte_s = val_r[int'(idx_r) * BYTE_W +: BYTE_W];
        cnt_s  = lead_cnt(byte_s, op_r);
        sat_s  = (cnt_s == CNT_W'(BYTE_W));
`ifdef BITCNT_EARLY_EXIT_EN
        add_s  = cnt_s;
        last_s = (idx_r == IDX_W'(0)) || !sat_s;
`else
        // Once an unsaturated byte has been seen, later bytes contribute nothing.
        if (stop_r) begin
            add_s = CNT_W'(0);
        end else begin
            add_s = cnt_s;
        end
        last_s = (idx_r == IDX_W'(0));
`endif
        acc_nxt_s = acc_r + {{(ACC_W - CNT_W){1'b0}}, add_s};
    end

    // Next-state logic; flush overrides everything and returns to IDLE.
    always_comb begin
        state_nxt_s = state_r;
        if (flush_i) begin
            state_nxt_s = ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        state_nxt_s = ST_SCAN;
                    end else begin
                        state_nxt_s = ST_IDLE;
                    end
                end
                ST_SCAN: begin
                    if (last_s) begin
                        state_nxt_s = ST_DONE;
                    end else begin
                        state_nxt_s = ST_SCAN;
                    end
                end
                ST_DONE: begin
                    if (resp_ready_i) begin
                        state_nxt_s = ST_IDLE;
                    end else begin
                        state_nxt_s = ST_DONE;
                    end
                end
                default: state_nxt_s = ST_IDLE;
            endcase
        end
    end

    // State, operand capture, accumulation and registered response outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            val_r        <= {DATA_W{1'b0}};
            op_r         <= 1'b0;
            tag_r        <= {TAG_W{1'b0}};
            idx_r        <= IDX_W'(0);
            acc_r        <= ACC_W'(0);
            res_r        <= {DATA_W{1'b0}};
            tag_out_r    <= {TAG_W{1'b0}};
            resp_valid_r <= 1'b0;
            busy_r       <= 1'b0;
`ifndef BITCNT_EARLY_EXIT_EN
            stop_r       <= 1'b0;
`endif
        end else begin
            state_r      <= state_nxt_s;
            busy_r       <= (state_nxt_s != ST_IDLE);
            resp_valid_r <= (state_nxt_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (accept_s) begin
                        val_r  <= val_i;
                        op_r   <= cnt_en_i;
                        tag_r  <= tag_i;
                        idx_r  <= IDX_W'(NBYTES - 1);
                        acc_r  <= ACC_W'(0);
`ifndef BITCNT_EARLY_EXIT_EN
                        stop_r <= 1'b0;
`endif
                    end else begin
                        acc_r <= acc_r;
                    end
                end
                ST_SCAN: begin
                    acc_r  <= acc_nxt_s;
                    idx_r  <= idx_r - IDX_W'(1);
`ifndef BITCNT_EARLY_EXIT_EN
                    stop_r <= stop_r | !sat_s;
`endif
                    if (state_nxt_s == ST_DONE) begin
                        res_r     <= {{(DATA_W - ACC_W){1'b0}}, acc_nxt_s};
                        tag_out_r <= tag_r;
                    end else begin
                        res_r     <= {DATA_W{1'b0}};
                        tag_out_r <= {TAG_W{1'b0}};
                    end
                end
                ST_DONE: begin
                    // Result is held until the consumer takes it or a flush drops it.
                    if (state_nxt_s != ST_DONE) begin
                        res_r     <= {DATA_W{1'b0}};
                        tag_out_r <= {TAG_W{1'b0}};
                    end else begin
                        res_r     <= res_r;
                        tag_out_r <= tag_out_r;
                    end
                end
                default: begin
                    res_r     <= {DATA_W{1'b0}};
                    tag_out_r <= {TAG_W{1'b0}};
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bitcount_seq_unit.sv
// Testbench for bitcount_seq_unit: table of directed CLZ/CLO vectors plus
// hand-written sequences for backpressure, flush and mid-operation reset.
module tb_bitcount_seq_unit;

    logic        clk;
    logic        rst;
    logic        flush_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        cnt_en_i;
    logic [31:0] val_i;
    logic [4:0]  tag_i;
    logic        resp_valid_o;
    logic        resp_ready_i;
    logic [31:0] res_o;
    logic [4:0]  tag_o;
    logic        busy_o;

    int total = 0;
    int bad   = 0;

    bitcount_seq_unit dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .req_valid_i  (req_valid_i),
        .req_ready_o  (req_ready_o),
        .cnt_en_i     (cnt_en_i),
        .val_i        (val_i),
        .tag_i        (tag_i),
        .resp_valid_o (resp_valid_o),
        .resp_ready_i (resp_ready_i),
        .res_o        (res_o),
        .tag_o        (tag_o),
        .busy_o       (busy_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        op;
        logic [31:0] val;
        logic [4:0]  tag;
        logic [31:0] exp_res;
        int          k_early;
    } vec_t;

    vec_t vecs [12];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%08h expected=0x%08h", name, got, exp);
        end
    endtask

    function automatic int exp_k(input int k_early);
`ifdef BITCNT_EARLY_EXIT_EN
        return k_early;
`else
        return (k_early > 0) ? 4 : 4;
`endif
    endfunction

    // Issue a request and wait for resp_valid_o; returns observed latency (99 = timeout).
    task automatic issue(input logic op, input logic [31:0] val, input logic [4:0] tag,
                         output int k);
        int w;
        w = 0;
        while (!req_ready_o && w < 20) begin
            @(posedge clk); #1;
            w++;
        end
        check("req_ready_before_issue", {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b1;
        cnt_en_i    = op;
        val_i       = val;
        tag_i       = tag;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        val_i       = 32'd0;
        tag_i       = 5'd0;
        k = 0;
        while (k < 10) begin
            @(posedge clk); #1;
            k++;
            if (resp_valid_o) break;
        end
        if (!resp_valid_o) k = 99;
    endtask

    // Full operation with immediate handshake and result checks.
    task automatic do_op(input string name, input logic op, input logic [31:0] val,
                         input logic [4:0] tag, input logic [31:0] exp_res, input int k_early);
        int k;
        issue(op, val, tag, k);
        check({name, "_lat"}, k, exp_k(k_early));
        check({name, "_res"}, res_o, exp_res);
        check({name, "_tag"}, {27'd0, tag_o}, {27'd0, tag});
        resp_ready_i = 1'b1;
        @(posedge clk); #1;
        resp_ready_i = 1'b0;
        check({name, "_idle"}, {30'd0, busy_o, resp_valid_o}, 32'd0);
    endtask

    initial begin
        int k;
        vecs[0]  = '{1'b0, 32'h0000_0001, 5'd1,  32'd31, 4};
        vecs[1]  = '{1'b0, 32'h8000_0000, 5'd2,  32'd0,  1};
        vecs[2]  = '{1'b0, 32'h0000_0000, 5'd3,  32'd32, 4};
        vecs[3]  = '{1'b1, 32'hFFFF_FFFF, 5'd4,  32'd32, 4};
        vecs[4]  = '{1'b1, 32'h7FFF_FFFF, 5'd5,  32'd0,  1};
        vecs[5]  = '{1'b0, 32'h00FF_0000, 5'd6,  32'd8,  2};
        vecs[6]  = '{1'b1, 32'hFFFF_8000, 5'd7,  32'd17, 3};
        vecs[7]  = '{1'b0, 32'h0000_0080, 5'd8,  32'd24, 4};
        vecs[8]  = '{1'b1, 32'hFE00_0000, 5'd9,  32'd7,  1};
        vecs[9]  = '{1'b0, 32'h0001_0000, 5'd10, 32'd15, 2};
        vecs[10] = '{1'b1, 32'hFFF0_1234, 5'd31, 32'd12, 2};
        vecs[11] = '{1'b0, 32'h00F0_0000, 5'd17, 32'd8,  2};

        rst = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; cnt_en_i = 1'b0;
        val_i = 32'd0; tag_i = 5'd0; resp_ready_i = 1'b0;
        @(posedge clk); #1;
        check("rst_res", res_o, 32'd0);
        check("rst_tag", {27'd0, tag_o}, 32'd0);
        check("rst_outs", {29'd0, resp_valid_o, busy_o, req_ready_o}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        @(posedge clk); #1;
        check("post_rst_ready", {31'd0, req_ready_o}, 32'd1);

        for (int i = 0; i < 12; i++) begin
            do_op($sformatf("vec%0d", i), vecs[i].op, vecs[i].val, vecs[i].tag,
                  vecs[i].exp_res, vecs[i].k_early);
        end

        // Backpressure: result held while consumer stalls.
        issue(1'b1, 32'hFFF0_1234, 5'd12, k);
        check("bp_lat", k, exp_k(2));
        for (int i = 0; i < 3; i++) begin
            check("bp_res", res_o, 32'd12);
            check("bp_tag", {27'd0, tag_o}, 32'd12);
            check("bp_flags", {29'd0, resp_valid_o, busy_o, req_ready_o}, 32'd6);
            @(posedge clk); #1;
        end
        resp_ready_i = 1'b1;
        req_valid_i  = 1'b1;
        cnt_en_i     = 1'b0;
        val_i        = 32'h0000_0001;
        @(posedge clk); #1;
        resp_ready_i = 1'b0;
        check("bp_idle", {30'd0, busy_o, resp_valid_o}, 32'd0);
        check("bp_ready", {31'd0, req_ready_o}, 32'd1);
        req_valid_i = 1'b0;
        @(posedge clk); #1;
        check("bp_no_accept", {31'd0, busy_o}, 32'd0);

        // Flush in the second scan cycle drops the operation.
        req_valid_i = 1'b1; cnt_en_i = 1'b0; val_i = 32'h0000_00FF; tag_i = 5'd20;
        @(posedge clk); #1;
        req_valid_i = 1'b0;
        @(posedge clk); #1;
        check("fl_scan_busy", {31'd0, busy_o}, 32'd1);
        flush_i = 1'b1;
        #1;
        check("fl_ready_low", {31'd0, req_ready_o}, 32'd0);
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("fl_idle", {30'd0, busy_o, resp_valid_o}, 32'd0);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("fl_no_resp", {31'd0, resp_valid_o}, 32'd0);
        end
        do_op("fl_next", 1'b0, 32'h0001_0000, 5'd21, 32'd15, 2);

        // Async reset while holding a result in DONE.
        issue(1'b0, 32'h0000_0001, 5'd22, k);
        check("rs_lat", k, exp_k(4));
        check("rs_res_before", res_o, 32'd31);
        #2;
        rst = 1'b1;
        #1;
        check("rs_res", res_o, 32'd0);
        check("rs_flags", {29'd0, resp_valid_o, busy_o, req_ready_o}, 32'd0);
        @(posedge clk); #2;
        rst = 1'b0;
        #1;
        check("rs_ready", {31'd0, req_ready_o}, 32'd1);
        @(posedge clk); #1;
        do_op("b2b0", 1'b1, 32'hFFFF_FF00, 5'd23, 32'd24, 4);
        do_op("b2b1", 1'b0, 32'h0000_4000, 5'd24, 32'd17, 3);
        do_op("b2b2", 1'b1, 32'h8000_0000, 5'd25, 32'd1,  1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
